// File: rtl/nf_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf_lsu_pkg
//  Description : Shared types and constants for the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package nf_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;

  localparam logic [3:0] c_BE_NONE    = 4'b0000;
  localparam logic [3:0] c_BE_BYTE0   = 4'b0001;
  localparam logic [3:0] c_BE_HALF_LO = 4'b0011;
  localparam logic [3:0] c_BE_HALF_HI = 4'b1100;
  localparam logic [3:0] c_BE_WORD    = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/nf_lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : nf_lsu_ctrl_if
//  Description : Data-memory bus between the LSU (master) and memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface nf_lsu_ctrl_if;

  logic [31:0] addr_dm;
  logic [31:0] wd_dm;
  logic        we_dm;
  logic [3:0]  be_dm;
  logic        req_dm;
  logic        ack_dm;
  logic [31:0] rd_dm;

  modport master (
    output addr_dm, wd_dm, we_dm, be_dm, req_dm,
    input  ack_dm, rd_dm
  );

  modport slave (
    input  addr_dm, wd_dm, we_dm, be_dm, req_dm,
    output ack_dm, rd_dm
  );

endinterface
`default_nettype wire

// File: rtl/nf_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : nf_lsu_align
//  Description : Byte-lane formatting of store requests and load extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf_lsu_align
  import nf_lsu_pkg::*;
(
  input  wire logic [1:0]  i_addr_lo,
  input  wire logic [1:0]  i_size,
  input  wire logic [31:0] i_wd,
  input  wire logic [1:0]  i_ld_off,
  input  wire logic [1:0]  i_ld_size,
  input  wire logic        i_ld_sign,
  input  wire logic [31:0] i_rd,
  output logic      [3:0]  o_be,
  output logic      [31:0] o_wd,
  output logic             o_misalign,
  output logic      [31:0] o_ld
);

  logic [31:0] w_shift;

  always_comb begin
    o_be       = c_BE_NONE;
    o_wd       = i_wd;
    o_misalign = 1'b0;
    case (i_size)
      LSU_B: begin
        o_be = c_BE_BYTE0 << i_addr_lo;
        o_wd = {4{i_wd[7:0]}};
      end
      LSU_H: begin
        o_be       = i_addr_lo[1] ? c_BE_HALF_HI : c_BE_HALF_LO;
        o_wd       = {2{i_wd[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      LSU_W: begin
        o_be       = c_BE_WORD;
        o_misalign = |i_addr_lo;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 before truncating and extending.
  assign w_shift = i_rd >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld = w_shift;
    case (i_ld_size)
      LSU_B:   o_ld = {{24{i_ld_sign & w_shift[7]}},  w_shift[7:0]};
      LSU_H:   o_ld = {{16{i_ld_sign & w_shift[15]}}, w_shift[15:0]};
      default: o_ld = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/nf_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nf_lsu_ctrl
//  Description : Load/store unit controller: IDLE/WAIT/DONE bus FSM with
//                ack timeout, pipeline stall generation and load alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf_lsu_ctrl
  import nf_lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        lsu_req_imem,
  input  wire logic        lsu_we_imem,
  input  wire logic [31:0] lsu_addr_imem,
  input  wire logic [31:0] lsu_wd_imem,
  input  wire logic [1:0]  lsu_size_imem,
  input  wire logic        lsu_sign_imem,
  output logic      [31:0] lsu_rd_iwb,
  output logic             req_ack_dm,
  output logic             lsu_err,
  nf_lsu_ctrl_if.master    dm
);

  localparam int               c_CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] c_ST_IDLE = ST_IDLE;
  localparam logic [1:0] c_ST_WAIT = ST_WAIT;
  localparam logic [1:0] c_ST_DONE = ST_DONE;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wd;
  logic               r_we;
  logic [3:0]         r_be;
  logic               r_req;
  logic [31:0]        r_rd;
  logic               r_err;
  logic [1:0]         r_ld_off;
  logic [1:0]         r_ld_size;
  logic               r_ld_sign;

  logic [3:0]         w_be;
  logic [31:0]        w_wd;
  logic               w_misalign;
  logic [31:0]        w_ld;

  nf_lsu_align u_align (
    .i_addr_lo  (lsu_addr_imem[1:0]),
    .i_size     (lsu_size_imem),
    .i_wd       (lsu_wd_imem),
    .i_ld_off   (r_ld_off),
    .i_ld_size  (r_ld_size),
    .i_ld_sign  (r_ld_sign),
    .i_rd       (dm.rd_dm),
    .o_be       (w_be),
    .o_wd       (w_wd),
    .o_misalign (w_misalign),
    .o_ld       (w_ld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_we      <= 1'b0;
      r_be      <= c_BE_NONE;
      r_req     <= 1'b0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_ld_off  <= 2'b00;
      r_ld_size <= LSU_B;
      r_ld_sign <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (lsu_req_imem) begin
            r_err <= w_misalign;
            if (w_misalign) begin
              r_rd    <= '0;
              r_state <= c_ST_DONE;
            end else begin
              r_addr    <= {lsu_addr_imem[31:2], 2'b00};
              r_wd      <= w_wd;
              r_we      <= lsu_we_imem;
              r_be      <= w_be;
              r_req     <= 1'b1;
              r_cnt     <= '0;
              r_ld_off  <= lsu_addr_imem[1:0];
              r_ld_size <= lsu_size_imem;
              r_ld_sign <= lsu_sign_imem;
              r_state   <= c_ST_WAIT;
            end
          end
        end
        c_ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (dm.ack_dm) begin
            r_req   <= 1'b0;
            r_rd    <= r_we ? '0 : w_ld;
            r_state <= c_ST_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            // Abandon the access; recovery of a hung slave is not our job.
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_rd    <= '0;
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign req_ack_dm = ((r_state == c_ST_IDLE) && !lsu_req_imem) || (r_state == c_ST_DONE);
  assign lsu_err    = (r_state == c_ST_DONE) && r_err;
  assign lsu_rd_iwb = r_rd;

  assign dm.addr_dm = r_addr;
  assign dm.wd_dm   = r_wd;
  assign dm.we_dm   = r_we;
  assign dm.be_dm   = r_be;
  assign dm.req_dm  = r_req;

endmodule
`default_nettype wire

// File: tb/tb_nf_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf_lsu_ctrl
//  Description : Directed scoreboard bench for nf_lsu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nf_lsu_ctrl;
  import nf_lsu_pkg::*;

  localparam int c_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_imem, lsu_we_imem, lsu_sign_imem;
  logic [31:0] lsu_addr_imem, lsu_wd_imem;
  logic [1:0]  lsu_size_imem;
  logic [31:0] lsu_rd_iwb;
  logic        req_ack_dm, lsu_err;

  logic        to_req;
  logic [31:0] to_rd;
  logic        to_ack, to_err;

  always #5 clk = ~clk;

  nf_lsu_ctrl_if dm_if ();
  nf_lsu_ctrl_if dm_to ();

  nf_lsu_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .lsu_req_imem  (lsu_req_imem),
    .lsu_we_imem   (lsu_we_imem),
    .lsu_addr_imem (lsu_addr_imem),
    .lsu_wd_imem   (lsu_wd_imem),
    .lsu_size_imem (lsu_size_imem),
    .lsu_sign_imem (lsu_sign_imem),
    .lsu_rd_iwb    (lsu_rd_iwb),
    .req_ack_dm    (req_ack_dm),
    .lsu_err       (lsu_err),
    .dm            (dm_if)
  );

  nf_lsu_ctrl #(.ACK_TIMEOUT(c_TO)) dut_to (
    .clk           (clk),
    .rst           (rst),
    .lsu_req_imem  (to_req),
    .lsu_we_imem   (lsu_we_imem),
    .lsu_addr_imem (lsu_addr_imem),
    .lsu_wd_imem   (lsu_wd_imem),
    .lsu_size_imem (lsu_size_imem),
    .lsu_sign_imem (lsu_sign_imem),
    .lsu_rd_iwb    (to_rd),
    .req_ack_dm    (to_ack),
    .lsu_err       (to_err),
    .dm            (dm_to)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;
  exp_t sb[$];

  logic [3:0]  last_be;
  logic [31:0] last_wd, last_rd;
  int          last_waits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_misal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00: case (off)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] rd, input logic [1:0] off,
                                       input logic [1:0] size, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[off*8 +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   return sign ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sign ? {{16{h[15]}}, h} : {16'h0, h};
      default: return rd;
    endcase
  endfunction

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input logic sign, input int ack_at,
                        input logic [31:0] rdv);
    exp_t e;
    logic bad, done;
    bad     = m_misal(size, addr[1:0]);
    e.err   = bad || (ack_at == 0);
    e.rd    = (e.err || we) ? 32'h0 : m_ld(rdv, addr[1:0], size, sign);
    e.waits = bad ? 0 : ((ack_at == 0) ? 255 : ack_at);
    sb.push_back(e);

    @(negedge clk);
    lsu_req_imem  = 1'b1;
    lsu_we_imem   = we;
    lsu_addr_imem = addr;
    lsu_wd_imem   = wd;
    lsu_size_imem = size;
    lsu_sign_imem = sign;
    dm_if.ack_dm  = 1'b0;
    dm_if.rd_dm   = rdv;
    #1;
    chk("stall_idle", {31'h0, req_ack_dm}, 32'h0);

    done       = 1'b0;
    last_waits = 0;
    for (int n = 1; n <= 300 && !done; n++) begin
      @(negedge clk);
      dm_if.ack_dm = (n == ack_at);
      #1;
      if (req_ack_dm) begin
        done = 1'b1;
      end else begin
        last_waits++;
        last_be = dm_if.be_dm;
        last_wd = dm_if.wd_dm;
        chk("wait_req", {31'h0, dm_if.req_dm}, 32'h1);
        chk("wait_addr", dm_if.addr_dm, {addr[31:2], 2'b00});
        chk("wait_be", {28'h0, dm_if.be_dm}, {28'h0, m_be(size, addr[1:0])});
        chk("wait_wd", dm_if.wd_dm, m_wd(size, wd));
        chk("wait_we", {31'h0, dm_if.we_dm}, {31'h0, we});
      end
    end
    chk("done_reached", {31'h0, done}, 32'h1);

    e = sb.pop_front();
    last_rd = lsu_rd_iwb;
    chk("done_rd", lsu_rd_iwb, e.rd);
    chk("done_err", {31'h0, lsu_err}, {31'h0, e.err});
    chk("done_req", {31'h0, dm_if.req_dm}, 32'h0);
    chk("wait_cycles", 32'(last_waits), 32'(e.waits));

    @(negedge clk);
    lsu_req_imem = 1'b0;
    dm_if.ack_dm = 1'b0;
    #1;
    chk("after_err", {31'h0, lsu_err}, 32'h0);
    chk("after_ack", {31'h0, req_ack_dm}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic done;
    rst           = 1'b1;
    lsu_req_imem  = 1'b0;
    lsu_we_imem   = 1'b0;
    lsu_addr_imem = 32'h0;
    lsu_wd_imem   = 32'h0;
    lsu_size_imem = LSU_W;
    lsu_sign_imem = 1'b0;
    to_req        = 1'b0;
    dm_if.ack_dm  = 1'b0;
    dm_if.rd_dm   = 32'h0;
    dm_to.ack_dm  = 1'b0;
    dm_to.rd_dm   = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", lsu_rd_iwb, 32'h0);
    chk("rst_req", {31'h0, dm_if.req_dm}, 32'h0);
    chk("rst_we", {31'h0, dm_if.we_dm}, 32'h0);
    chk("rst_be", {28'h0, dm_if.be_dm}, 32'h0);
    chk("rst_addr", dm_if.addr_dm, 32'h0);
    chk("rst_wd", dm_if.wd_dm, 32'h0);
    chk("rst_err", {31'h0, lsu_err}, 32'h0);
    chk("rst_ack", {31'h0, req_ack_dm}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Stray ack while idle must not start anything.
    @(negedge clk);
    dm_if.ack_dm = 1'b1;
    @(negedge clk);
    dm_if.ack_dm = 1'b0;
    #1;
    chk("stray_req", {31'h0, dm_if.req_dm}, 32'h0);
    chk("stray_ack", {31'h0, req_ack_dm}, 32'h1);
    chk("stray_err", {31'h0, lsu_err}, 32'h0);

    access(1'b0, 32'h100, 32'h0, LSU_W, 1'b0, 1, 32'hDEADBEEF);
    chk("word_rd", last_rd, 32'hDEADBEEF);
    chk("word_be", {28'h0, last_be}, 32'hF);
    chk("word_lat", 32'(last_waits), 32'd1);

    access(1'b0, 32'h103, 32'h0, LSU_B, 1'b1, 2, 32'h80FFFFFF);
    chk("sbyte_be", {28'h0, last_be}, 32'h8);
    chk("sbyte_rd", last_rd, 32'hFFFFFF80);

    access(1'b0, 32'h103, 32'h0, LSU_B, 1'b0, 1, 32'h80FFFFFF);
    chk("ubyte_rd", last_rd, 32'h00000080);

    access(1'b1, 32'h102, 32'h1234ABCD, LSU_H, 1'b0, 5, 32'h55555555);
    chk("hst_wd", last_wd, 32'hABCDABCD);
    chk("hst_be", {28'h0, last_be}, 32'hC);
    chk("hst_waits", 32'(last_waits), 32'd5);
    chk("hst_rd", last_rd, 32'h0);

    access(1'b0, 32'h102, 32'h0, LSU_H, 1'b1, 3, 32'h80017FFF);
    chk("shalf_rd", last_rd, 32'hFFFF8001);

    access(1'b0, 32'h101, 32'h0, LSU_W, 1'b0, 1, 32'h12345678);
    chk("misal_rd", last_rd, 32'h0);
    chk("misal_waits", 32'(last_waits), 32'd0);

    access(1'b1, 32'h101, 32'h000000A5, LSU_B, 1'b0, 3, 32'h0);
    chk("bst_wd", last_wd, 32'hA5A5A5A5);
    chk("bst_be", {28'h0, last_be}, 32'h2);

    access(1'b0, 32'h103, 32'h0, LSU_H, 1'b0, 1, 32'h0);
    access(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 1, 32'h0);

    access(1'b0, 32'h100, 32'h0, LSU_H, 1'b0, 2, 32'h1234F00D);
    chk("uhalf_rd", last_rd, 32'h0000F00D);

    // Timeout on the short-timeout instance: ack never comes.
    e.rd = 32'h0; e.err = 1'b1; e.waits = c_TO;
    sb.push_back(e);
    @(negedge clk);
    to_req        = 1'b1;
    lsu_we_imem   = 1'b0;
    lsu_addr_imem = 32'h40;
    lsu_size_imem = LSU_W;
    #1;
    chk("to_stall", {31'h0, to_ack}, 32'h0);
    done       = 1'b0;
    last_waits = 0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      #1;
      if (to_ack) done = 1'b1;
      else begin
        last_waits++;
        chk("to_req_hi", {31'h0, dm_to.req_dm}, 32'h1);
      end
    end
    chk("to_done", {31'h0, done}, 32'h1);
    e = sb.pop_front();
    chk("to_waits", 32'(last_waits), 32'(e.waits));
    chk("to_err", {31'h0, to_err}, {31'h0, e.err});
    chk("to_rd", to_rd, e.rd);
    chk("to_req_lo", {31'h0, dm_to.req_dm}, 32'h0);
    @(negedge clk);
    to_req = 1'b0;
    #1;
    chk("to_err_pulse", {31'h0, to_err}, 32'h0);

    // Reset during WAIT abandons the access; the late ack is ignored.
    access(1'b0, 32'h10, 32'h0, LSU_W, 1'b0, 1, 32'hCAFEF00D);
    @(negedge clk);
    lsu_req_imem  = 1'b1;
    lsu_addr_imem = 32'h200;
    lsu_size_imem = LSU_W;
    dm_if.rd_dm   = 32'h11223344;
    @(negedge clk);
    #1;
    chk("rw_req1", {31'h0, dm_if.req_dm}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_req2", {31'h0, dm_if.req_dm}, 32'h1);
    @(negedge clk);
    rst          = 1'b0;
    lsu_req_imem = 1'b0;
    dm_if.ack_dm = 1'b1;
    #1;
    chk("rw_req_lo", {31'h0, dm_if.req_dm}, 32'h0);
    chk("rw_ack", {31'h0, req_ack_dm}, 32'h1);
    chk("rw_err", {31'h0, lsu_err}, 32'h0);
    @(negedge clk);
    dm_if.ack_dm = 1'b0;
    #1;
    chk("rw_ignored_req", {31'h0, dm_if.req_dm}, 32'h0);
    chk("rw_rd", lsu_rd_iwb, 32'h0);
    chk("rw_ack2", {31'h0, req_ack_dm}, 32'h1);
    chk("rw_err2", {31'h0, lsu_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
